// File: rtl/pool_stream_pkg.sv
// Shared types and sizes for the pooling input stream.
package pool_stream_pkg;

  localparam int unsigned PIN    = 8;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DATA_W = PIN * LANE_W;

  // One stream beat: PIN channel lanes of LANE_W bits, lane i at [8i+7:8i]
  typedef logic [DATA_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid delay line matching the memory read latency, plus the output beat register.
module rd_lat_pipe
  import pool_stream_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              inflight_c
);

  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] vnext;

  // Next value of the valid shift register (stage 0 takes the read strobe)
  generate
    if (RD_LAT == 1) begin : g_one
      assign vnext = en;
    end else begin : g_many
      assign vnext = {vpipe[RD_LAT-2:0], en};
    end
  endgenerate

  // Any read still travelling through the memory pipeline
  assign inflight_c = |vpipe;

  // Shift valid bits; capture read data when the oldest read arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      vpipe <= vnext;
      valid <= vpipe[RD_LAT-1];
      if (vpipe[RD_LAT-1]) begin
        data <= rd_data;
      end
    end
  end

endmodule

// File: rtl/fmap_stream_src.sv
// Reads a stored feature map and streams it in raster order, one channel group per beat.
module fmap_stream_src
  import pool_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  input  logic [15:0]       channels,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pixel_gap,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 8;

  state_t            state;
  logic [CNT_W-1:0]  width_r, height_r, groups_r;
  logic [GAP_W-1:0]  gap_r, gap_cnt;
  logic [CNT_W-1:0]  grp_cnt, col_cnt, row_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              last_grp, last_col, last_row;
  logic              inflight_c;

  assign last_grp = (grp_cnt == groups_r - CNT_W'(1));
  assign last_col = (col_cnt == width_r - CNT_W'(1));
  assign last_row = (row_cnt == height_r - CNT_W'(1));

  // Frame sequencer: configuration capture, raster counters and read issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      width_r   <= '0;
      height_r  <= '0;
      groups_r  <= '0;
      gap_r     <= '0;
      gap_cnt   <= '0;
      grp_cnt   <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      addr_cnt  <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            width_r  <= img_width;
            height_r <= img_height;
            groups_r <= channels >> 3;
            gap_r    <= pixel_gap;
            gap_cnt  <= '0;
            grp_cnt  <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            addr_cnt <= base_addr;
            busy     <= 1'b1;
            if (img_width == '0 || img_height == '0 || (channels >> 3) == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_cnt;
          addr_cnt  <= addr_cnt + ADDR_W'(1);
          if (last_grp) begin
            grp_cnt <= '0;
            if (last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + CNT_W'(1);
            end else begin
              col_cnt <= col_cnt + CNT_W'(1);
            end
            if (last_col && last_row) begin
              state <= DRAIN;
            end else if (gap_r != '0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else begin
            grp_cnt <= grp_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == gap_r - GAP_W'(1)) begin
            state <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DRAIN: begin
          // Last read has left the strobe and the latency pipe: final beat is on the output now
          if (!mem_rd_en && !inflight_c) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_lat_pipe #(
    .RD_LAT(RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (mem_rd_en),
    .rd_data   (mem_rd_data),
    .data      (data_out),
    .valid     (valid_out),
    .inflight_c(inflight_c)
  );

endmodule

// File: tb/tb_fmap_stream_src.sv
// Directed bench: two instances (read latency 1 and 2) with behavioural memories.
module tb_fmap_stream_src;
  import pool_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance 1: RD_LAT = 1 ----------------
  logic        start;
  logic [15:0] img_width, img_height, channels, base_addr;
  logic [7:0]  pixel_gap;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  beat_t       mem_rd_data, data_out;
  logic        valid_out, busy, done;

  fmap_stream_src #(.ADDR_W(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .img_width(img_width), .img_height(img_height), .channels(channels),
    .base_addr(base_addr), .pixel_gap(pixel_gap),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done)
  );

  // ---------------- instance 2: RD_LAT = 2 ----------------
  logic        start2;
  logic [15:0] img_width2, img_height2, channels2, base_addr2;
  logic [7:0]  pixel_gap2;
  logic [15:0] mem_addr2;
  logic        mem_rd_en2;
  beat_t       mem_rd_data2, data_out2, m2_s0;
  logic        valid_out2, busy2, done2;

  fmap_stream_src #(.ADDR_W(16), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .img_width(img_width2), .img_height(img_height2), .channels(channels2),
    .base_addr(base_addr2), .pixel_gap(pixel_gap2),
    .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_rd_data(mem_rd_data2),
    .data_out(data_out2), .valid_out(valid_out2), .busy(busy2), .done(done2)
  );

  function automatic beat_t rep8(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Memory word k holds byte k[7:0] in every lane
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= rep8(mem_addr[7:0]);
  always @(posedge clk) begin
    if (mem_rd_en2) m2_s0 <= rep8(mem_addr2[7:0]);
    mem_rd_data2 <= m2_s0;
  end

  // ---------------- monitors (sample on falling edge) ----------------
  beat_t       beat_q[$];
  int          beat_cyc[$];
  logic [15:0] addr_q[$];
  int          en_cyc[$];
  int          done_cnt, done_cyc;
  logic        done_prev, busy_after_done;

  always @(negedge clk) begin
    if (valid_out) begin beat_q.push_back(data_out); beat_cyc.push_back(cyc); end
    if (mem_rd_en) begin addr_q.push_back(mem_addr); en_cyc.push_back(cyc); end
    if (done_prev) busy_after_done = busy;
    if (done) begin done_cnt++; done_cyc = cyc; end
    done_prev = done;
  end

  beat_t       beat2_q[$];
  int          beat2_cyc[$];
  logic [15:0] addr2_q[$];
  int          en2_cyc[$];
  int          done2_cnt, done2_cyc;

  always @(negedge clk) begin
    if (valid_out2) begin beat2_q.push_back(data_out2); beat2_cyc.push_back(cyc); end
    if (mem_rd_en2) begin addr2_q.push_back(mem_addr2); en2_cyc.push_back(cyc); end
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    beat_q.delete(); beat_cyc.delete(); addr_q.delete(); en_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_after_done = 1'bx;
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h,
                             input logic [15:0] ch, input logic [15:0] base,
                             input logic [7:0] gap);
    img_width = w; img_height = h; channels = ch; base_addr = base; pixel_gap = gap;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    check({tag, "_timeout"}, 64'(done_cnt == 0), 64'd0);
    repeat (3) tick();
  endtask

  // Full frame check for instance 1: count, address order, data, spacing, latency, done
  task automatic check_frame(input string tag, input int nbeats, input logic [15:0] base,
                             input int groups, input int gap);
    int nb = (beat_q.size() < nbeats) ? beat_q.size() : nbeats;
    int na = (addr_q.size() < nbeats) ? addr_q.size() : nbeats;
    int bad_addr = 0, bad_data = 0, bad_space = 0, bad_lat = 0;
    logic [15:0] ea;
    check({tag, "_beats"}, 64'(beat_q.size()), 64'(nbeats));
    check({tag, "_reads"}, 64'(addr_q.size()), 64'(nbeats));
    for (int i = 0; i < na; i++) begin
      ea = base + 16'(i);
      if (addr_q[i] !== ea) bad_addr++;
    end
    for (int i = 0; i < nb; i++) begin
      ea = base + 16'(i);
      if (beat_q[i] !== rep8(ea[7:0])) bad_data++;
      if (i > 0 && beat_cyc[i] != beat_cyc[i-1] + (((i % groups) == 0) ? gap + 1 : 1)) bad_space++;
      if (i < na && beat_cyc[i] != en_cyc[i] + 2) bad_lat++;
    end
    check({tag, "_addr_order"}, 64'(bad_addr), 64'd0);
    check({tag, "_data"}, 64'(bad_data), 64'd0);
    check({tag, "_spacing"}, 64'(bad_space), 64'd0);
    check({tag, "_latency"}, 64'(bad_lat), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (nb > 0) check({tag, "_done_time"}, 64'(done_cyc), 64'(beat_cyc[nb-1] + 1));
    check({tag, "_busy_fall"}, 64'(busy_after_done), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int bad;
    rst = 1'b1;
    start = 1'b0; img_width = '0; img_height = '0; channels = '0; base_addr = '0; pixel_gap = '0;
    start2 = 1'b0; img_width2 = '0; img_height2 = '0; channels2 = '0; base_addr2 = '0; pixel_gap2 = '0;
    clear_logs();
    repeat (3) tick();

    // Reset values
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: 4x4, 16 channels, gap 2
    clear_logs();
    start_frame(16'd4, 16'd4, 16'd16, 16'h0000, 8'd2);
    check("t1_busy_rise", 64'(busy), 64'd1);
    wait_done("t1", 2000);
    check_frame("t1", 32, 16'h0000, 2, 2);

    // 2: gapless 3x3 at base 0x100
    clear_logs();
    start_frame(16'd3, 16'd3, 16'd16, 16'h0100, 8'd0);
    wait_done("t2", 2000);
    check_frame("t2", 18, 16'h0100, 2, 0);

    // 3: degenerate configs
    clear_logs();
    start_frame(16'd4, 16'd4, 16'd7, 16'h0000, 8'd0);
    check("t3a_done_next", 64'(done), 64'd1);
    check("t3a_busy", 64'(busy), 64'd1);
    repeat (6) tick();
    check("t3a_beats", 64'(beat_q.size()), 64'd0);
    check("t3a_reads", 64'(addr_q.size()), 64'd0);
    check("t3a_done_cnt", 64'(done_cnt), 64'd1);
    clear_logs();
    start_frame(16'd0, 16'd4, 16'd16, 16'h0000, 8'd0);
    check("t3b_done_next", 64'(done), 64'd1);
    repeat (6) tick();
    check("t3b_beats", 64'(beat_q.size()), 64'd0);
    check("t3b_reads", 64'(addr_q.size()), 64'd0);
    check("t3b_done_cnt", 64'(done_cnt), 64'd1);

    // 4: start while busy with a changed width is ignored
    clear_logs();
    start_frame(16'd4, 16'd4, 16'd16, 16'h0000, 8'd2);
    repeat (10) tick();
    img_width = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 2000);
    check_frame("t4", 32, 16'h0000, 2, 2);
    clear_logs();
    start_frame(16'd9, 16'd4, 16'd16, 16'h0000, 8'd2);
    wait_done("t4b", 4000);
    check_frame("t4b", 72, 16'h0000, 2, 2);

    // 5: reset mid-frame
    clear_logs();
    start_frame(16'd4, 16'd4, 16'd16, 16'h0000, 8'd2);
    n = 0;
    while (beat_q.size() < 11 && n < 500) begin tick(); n++; end
    check("t5_reach_beat10", 64'(beat_q.size() >= 11), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_valid_clr", 64'(valid_out), 64'd0);
    check("t5_busy_clr", 64'(busy), 64'd0);
    check("t5_rd_en_clr", 64'(mem_rd_en), 64'd0);
    check("t5_data_clr", data_out, 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    clear_logs();
    repeat (20) tick();
    check("t5_quiet_beats", 64'(beat_q.size()), 64'd0);
    check("t5_quiet_reads", 64'(addr_q.size()), 64'd0);
    check("t5_quiet_busy", 64'(busy), 64'd0);
    clear_logs();
    start_frame(16'd4, 16'd4, 16'd16, 16'h0000, 8'd2);
    wait_done("t5b", 2000);
    check_frame("t5b", 32, 16'h0000, 2, 2);

    // 6: RD_LAT=2, 1x2, address wrap from 0xFFFE
    done2_cnt = 0; done2_cyc = 0;
    img_width2 = 16'd1; img_height2 = 16'd2; channels2 = 16'd16; base_addr2 = 16'hFFFE; pixel_gap2 = 8'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 200) begin tick(); n++; end
    check("t6_timeout", 64'(done2_cnt == 0), 64'd0);
    repeat (3) tick();
    check("t6_beats", 64'(beat2_q.size()), 64'd4);
    check("t6_reads", 64'(addr2_q.size()), 64'd4);
    if (addr2_q.size() == 4 && beat2_q.size() == 4) begin
      check("t6_addr0", 64'(addr2_q[0]), 64'hFFFE);
      check("t6_addr1", 64'(addr2_q[1]), 64'hFFFF);
      check("t6_addr2", 64'(addr2_q[2]), 64'h0000);
      check("t6_addr3", 64'(addr2_q[3]), 64'h0001);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (beat2_cyc[i] != en2_cyc[i] + 3) bad++;
        if (beat2_q[i] !== rep8(addr2_q[i][7:0])) bad++;
      end
      check("t6_lat_data", 64'(bad), 64'd0);
      check("t6_done_time", 64'(done2_cyc), 64'(beat2_cyc[3] + 1));
    end
    check("t6_done_cnt", 64'(done2_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_stream_src.md
Name: fmap_stream_src

Overview:
- Transmit end of the pooling input stream: reads a stored feature map from a BRAM-style memory and emits it as 64-bit beats (8 channels x 8 bits) on data_out/valid_out, ready to drive the data_in/valid_in ports of the max-pool stage.
- Emission order is raster: row-major pixels, and for each pixel, channels/8 consecutive channel-group beats (group 0 first).
- An optional idle gap can be inserted between spatial pixels.
- Control is a start/busy/done handshake driven by the layer sequencer.

Parameters:
- ADDR_W, 16, memory word-address width; addresses wrap modulo 2^ADDR_W.
- RD_LAT, 1, memory read latency in cycles (legal 1..4); mem_rd_data is valid RD_LAT cycles after mem_rd_en is sampled high.
- DATA_W, 64, beat width; fixed at PIN*8 with PIN=8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle frame start; ignored while busy
- img_width  in  16  pixels per row, sampled on start
- img_height  in  16  rows, sampled on start
- channels  in  16  channel count, sampled on start; groups = channels>>3
- base_addr  in  ADDR_W  word address of pixel (0,0) group 0, sampled on start
- pixel_gap  in  8  idle cycles inserted after each pixel except the last, sampled on start
- mem_addr  out  ADDR_W  read address
- mem_rd_en  out  1  read strobe
- mem_rd_data  in  DATA_W  read data
- data_out  out  DATA_W  stream beat, lane i = bits [8i+7:8i]
- valid_out  out  1  beat qualifier; no backpressure
- busy  out  1  high from the cycle after start through the done cycle
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous): state IDLE; all counters 0; the latency pipe is cleared; mem_addr=0, mem_rd_en=0, data_out=0, valid_out=0, busy=0, done=0.
- FSM states are IDLE, ISSUE, GAP, DRAIN, DONE.
- IDLE: when start=1, latch the configuration, clear the counters, and set the address counter to base_addr.
  - If width, height or groups = 0, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: each cycle, assert mem_rd_en with mem_addr = the address counter, then increment the address counter (wrapping).
  - Group counter runs 0..groups-1; pixel column 0..width-1; row 0..height-1.
  - After the last group of a pixel:
    - If it is the last pixel of the frame, go to DRAIN.
    - Otherwise, if pixel_gap > 0, go to GAP.
    - Otherwise stay in ISSUE.
- GAP: mem_rd_en=0 for exactly pixel_gap cycles, then ISSUE.
- Memory address of a beat = base + ((row*width + col)*groups + grp) mod 2^ADDR_W. It is produced by incrementing a running counter; there is no multiplier.
- Latency pipe: an RD_LAT-deep valid shift register follows mem_rd_en. When its output is 1, data_out <= mem_rd_data and valid_out <= 1; otherwise valid_out <= 0 and data_out holds its value.
  - A beat issued in cycle t appears on data_out/valid_out in cycle t+RD_LAT+1.
- DRAIN: wait until the latency pipe is empty and the last beat has been presented, then go to DONE.
- DONE: done=1 for one cycle, busy still 1; next state IDLE.
  - Normal frame: done is high exactly 1 cycle after the last valid_out.
  - Degenerate frame: start is sampled in cycle t, done is high in t+1, and valid_out is never asserted.
- The frame produces exactly width*height*groups beats.
- Beats of one pixel are contiguous (no gaps inside a pixel).
- Start while busy is ignored. Changing the config inputs mid-frame has no effect.
- channels not a multiple of 8: the remainder is dropped (floor), matching the max-pool channel-group count.
- Reset mid-frame: outputs go to reset values immediately. In-flight beats are discarded. No valid_out occurs after release until a new start.

Decomposition:
- Package pool_stream_pkg holds:
  - PIN=8, DATA_W=PIN*8 and LANE_W=8;
  - a typedef for the 64-bit beat;
  - the state enum (IDLE, ISSUE, GAP, DRAIN, DONE).
- Sub-module rd_lat_pipe: a parameterised RD_LAT-stage valid delay line with async clear, plus the output data register.
- FSM and counters live in fmap_stream_src.

Test Plan:
- Normal frame with gaps: RD_LAT=1, 4x4, channels=16, gap=2, base=0, mem[k]=k replicated per byte.
  - Expect 32 beats in back-to-back pairs separated by 2 idle cycles.
  - Expect mem_addr 0..31 in order; beat n data = n per byte.
  - Expect done 1 cycle after beat 31; busy falls the cycle after done.
- Gapless frame at offset base: 3x3, channels=16, gap=0, base=0x100.
  - Expect 18 consecutive valid_out cycles, addresses 0x100..0x111, beat order equal to address order.
  - Expect a single done pulse.
- Degenerate configs: channels=7 (groups=0), then width=0.
  - In each case expect done in the cycle after start is sampled, with zero valid_out and zero mem_rd_en.
- Start while busy: a second start pulse mid-frame with img_width changed to 9.
  - Expect the frame unaffected: still 32 beats, one done.
  - Expect a new start after done to run with the new config.
- Reset mid-frame: assert rst after beat 10.
  - Expect valid_out, busy and mem_rd_en at 0 immediately.
  - Expect no beats after release until a new start; the new frame is complete and correct.
- Latency and address wrap: RD_LAT=2, 1x2, channels=16, gap=0, base=0xFFFE.
  - Expect addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Expect each beat 3 cycles after its mem_rd_en, and done 1 cycle after the 4th beat.
